// File: rtl/axi4lite_xbar_pkg.sv
// Shared constants for the AXI4-Lite 1-to-N crossbar.
//   RESP_OKAY / RESP_DECERR : AXI response codes used by the crossbar itself.
//   R_* / W_*               : state encodings for the read and write FSMs.
package axi4lite_xbar_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Read FSM encodings
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;
    localparam logic [1:0] R_ERR  = 2'd3;

    // Write FSM encodings
    localparam logic [2:0] W_IDLE  = 3'd0;
    localparam logic [2:0] W_FWD   = 3'd1;
    localparam logic [2:0] W_RESP  = 3'd2;
    localparam logic [2:0] W_ERR_W = 3'd3;
    localparam logic [2:0] W_ERR_B = 3'd4;

endpackage

// File: rtl/axi4lite_addr_decode.sv
// Combinational address decoder for the AXI4-Lite crossbar.
// Ports:
//   addr : address to decode (ADDR_WIDTH)
//   hit  : one-hot target slave; lowest matching index wins (NUM_SLAVES)
//   err  : no slave matched, access is a decode error
module axi4lite_addr_decode
    import axi4lite_xbar_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE =
        {32'h8000_0000, 32'ha000_0048, 32'ha000_03f8},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK =
        {32'hf800_0000, 32'hffff_fff8, 32'hffff_fffc}
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] hit,
    output logic                  err
);

    // Scan from the highest index down so a lower matching index overwrites
    // any higher one, giving lowest-index priority with a one-hot result.
    always_comb begin
        hit = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit    = '0;
                hit[i] = 1'b1;
            end
        end
        err = (hit == '0);
    end

endmodule

// File: rtl/axi4lite_xbar_nslv.sv
// AXI4-Lite crossbar: one master port fanned out to NUM_SLAVES slave ports.
// Independent read and write FSMs, one outstanding transaction per direction.
// Unmapped addresses are answered locally with DECERR.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   ar*/r*                   : master read address / read data channels
//   aw*/w*/b*                : master write address / data / response channels
//   slv_*                    : slave-side mirrors, slave i at [i*W +: W]
module axi4lite_xbar_nslv
    import axi4lite_xbar_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE =
        {32'h8000_0000, 32'ha000_0048, 32'ha000_03f8},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK =
        {32'hf800_0000, 32'hffff_fff8, 32'hffff_fffc}
) (
    input  logic                             clk,
    input  logic                             rst,
    // master side
    input  logic                             arvalid,
    input  logic [ADDR_WIDTH-1:0]            araddr,
    output logic                             arready,
    output logic                             rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic [1:0]                       rresp,
    input  logic                             rready,
    input  logic                             awvalid,
    input  logic [ADDR_WIDTH-1:0]            awaddr,
    output logic                             awready,
    input  logic                             wvalid,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [DATA_WIDTH/8-1:0]          wstrb,
    output logic                             wready,
    output logic                             bvalid,
    output logic [1:0]                       bresp,
    input  logic                             bready,
    // slave side
    output logic [NUM_SLAVES-1:0]              slv_arvalid,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   slv_araddr,
    input  logic [NUM_SLAVES-1:0]              slv_arready,
    input  logic [NUM_SLAVES-1:0]              slv_rvalid,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   slv_rdata,
    input  logic [NUM_SLAVES*2-1:0]            slv_rresp,
    output logic [NUM_SLAVES-1:0]              slv_rready,
    output logic [NUM_SLAVES-1:0]              slv_awvalid,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   slv_awaddr,
    input  logic [NUM_SLAVES-1:0]              slv_awready,
    output logic [NUM_SLAVES-1:0]              slv_wvalid,
    output logic [NUM_SLAVES*DATA_WIDTH-1:0]   slv_wdata,
    output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] slv_wstrb,
    input  logic [NUM_SLAVES-1:0]              slv_wready,
    input  logic [NUM_SLAVES-1:0]              slv_bvalid,
    input  logic [NUM_SLAVES*2-1:0]            slv_bresp,
    output logic [NUM_SLAVES-1:0]              slv_bready
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [NUM_SLAVES-1:0] ar_hit, aw_hit;
    logic                  ar_err, aw_err;

    // Target is held one-hot so it can directly gate slave-side valid/ready.
    logic [1:0]            r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] r_addr_q,  r_addr_d;
    logic [NUM_SLAVES-1:0] r_tgt_q,   r_tgt_d;

    logic [2:0]            w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] w_addr_q,  w_addr_d;
    logic [NUM_SLAVES-1:0] w_tgt_q,   w_tgt_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q,  w_done_d;
    logic                  aw_hs, w_hs;

    axi4lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_ar_decode (
        .addr (araddr),
        .hit  (ar_hit),
        .err  (ar_err)
    );

    axi4lite_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_aw_decode (
        .addr (awaddr),
        .hit  (aw_hit),
        .err  (aw_err)
    );

    // Read path
    always_comb begin
        r_state_d   = r_state_q;
        r_addr_d    = r_addr_q;
        r_tgt_d     = r_tgt_q;
        arready     = 1'b0;
        rvalid      = 1'b0;
        rdata       = '0;
        rresp       = '0;
        slv_arvalid = '0;
        slv_araddr  = '0;
        slv_rready  = '0;
        case (r_state_q)
            R_IDLE: begin
                // The state register is already idle during reset; gating with
                // rst keeps arready low until reset is released.
                arready = !rst;
                if (arvalid && !rst) begin
                    r_addr_d  = araddr;
                    r_tgt_d   = ar_hit;
                    r_state_d = ar_err ? R_ERR : R_ADDR;
                end
            end
            R_ADDR: begin
                slv_arvalid = r_tgt_q;
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (r_tgt_q[i]) begin
                        slv_araddr[i*ADDR_WIDTH +: ADDR_WIDTH] = r_addr_q;
                    end
                end
                if ((slv_arready & r_tgt_q) != '0) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                slv_rready = r_tgt_q & {NUM_SLAVES{rready}};
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (r_tgt_q[i]) begin
                        rvalid = rvalid | slv_rvalid[i];
                        rdata  = rdata  | slv_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                        rresp  = rresp  | slv_rresp[i*2 +: 2];
                    end
                end
                if (rvalid && rready) begin
                    r_state_d = R_IDLE;
                end
            end
            R_ERR: begin
                rvalid = 1'b1;
                rresp  = RESP_DECERR;
                if (rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write path
    always_comb begin
        w_state_d   = w_state_q;
        w_addr_d    = w_addr_q;
        w_tgt_d     = w_tgt_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        bresp       = '0;
        slv_awvalid = '0;
        slv_awaddr  = '0;
        slv_wvalid  = '0;
        slv_wdata   = '0;
        slv_wstrb   = '0;
        slv_bready  = '0;
        case (w_state_q)
            W_IDLE: begin
                awready = !rst;
                if (awvalid && !rst) begin
                    w_addr_d  = awaddr;
                    w_tgt_d   = aw_hit;
                    w_state_d = aw_err ? W_ERR_W : W_FWD;
                end
            end
            W_FWD: begin
                // AW and W are forwarded independently; each one stops being
                // presented to the slave once its own handshake has happened.
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (w_tgt_q[i]) begin
                        if (!aw_done_q) begin
                            slv_awvalid[i] = 1'b1;
                            slv_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH] = w_addr_q;
                        end
                        if (!w_done_q) begin
                            slv_wvalid[i] = wvalid;
                            slv_wdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata;
                            slv_wstrb[i*STRB_W +: STRB_W] = wstrb;
                            wready = slv_wready[i];
                        end
                    end
                end
                aw_hs     = !aw_done_q && ((slv_awready & w_tgt_q) != '0);
                w_hs      = wvalid && wready;
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                slv_bready = w_tgt_q & {NUM_SLAVES{bready}};
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (w_tgt_q[i]) begin
                        bvalid = bvalid | slv_bvalid[i];
                        bresp  = bresp  | slv_bresp[i*2 +: 2];
                    end
                end
                if (bvalid && bready) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            W_ERR_W: begin
                // Swallow the single data beat of the unmapped write.
                wready = 1'b1;
                if (wvalid) begin
                    w_state_d = W_ERR_B;
                end
            end
            W_ERR_B: begin
                bvalid = 1'b1;
                bresp  = RESP_DECERR;
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_tgt_q   <= '0;
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_tgt_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_tgt_q   <= r_tgt_d;
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_tgt_q   <= w_tgt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axi4lite_xbar_nslv.sv
// Testbench for axi4lite_xbar_nslv: directed master transactions, three
// behavioural slave models, and a scoreboard monitor that pops expected
// R/B responses whenever a master-side handshake occurs.
`timescale 1ns/1ps
module tb_axi4lite_xbar_nslv;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          arvalid, arready, rvalid, rready;
    logic [AW-1:0] araddr;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic [AW-1:0] awaddr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp;

    logic [NS-1:0]    slv_arvalid, slv_arready, slv_rvalid, slv_rready;
    logic [NS*AW-1:0] slv_araddr, slv_awaddr;
    logic [NS*DW-1:0] slv_rdata, slv_wdata;
    logic [NS*2-1:0]  slv_rresp, slv_bresp;
    logic [NS-1:0]    slv_awvalid, slv_awready, slv_wvalid, slv_wready;
    logic [NS*SW-1:0] slv_wstrb;
    logic [NS-1:0]    slv_bvalid, slv_bready;

    axi4lite_xbar_nslv #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_SLAVES (NS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arvalid     (arvalid),
        .araddr      (araddr),
        .arready     (arready),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rready      (rready),
        .awvalid     (awvalid),
        .awaddr      (awaddr),
        .awready     (awready),
        .wvalid      (wvalid),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .wready      (wready),
        .bvalid      (bvalid),
        .bresp       (bresp),
        .bready      (bready),
        .slv_arvalid (slv_arvalid),
        .slv_araddr  (slv_araddr),
        .slv_arready (slv_arready),
        .slv_rvalid  (slv_rvalid),
        .slv_rdata   (slv_rdata),
        .slv_rresp   (slv_rresp),
        .slv_rready  (slv_rready),
        .slv_awvalid (slv_awvalid),
        .slv_awaddr  (slv_awaddr),
        .slv_awready (slv_awready),
        .slv_wvalid  (slv_wvalid),
        .slv_wdata   (slv_wdata),
        .slv_wstrb   (slv_wstrb),
        .slv_wready  (slv_wready),
        .slv_bvalid  (slv_bvalid),
        .slv_bresp   (slv_bresp),
        .slv_bready  (slv_bready)
    );

    // ---------------- slave models ----------------
    int            rd_delay [NS];
    logic [DW-1:0] rd_val   [NS];
    logic [NS-1:0] rd_busy, aw_got, w_got;
    int            rd_cnt   [NS];
    logic [AW-1:0] lat_waddr [NS];
    logic [DW-1:0] lat_wdata [NS];
    logic [SW-1:0] lat_wstrb [NS];
    int            wr_cnt   [NS];
    logic [AW-1:0] last_waddr [NS];
    logic [DW-1:0] last_wdata [NS];
    logic [SW-1:0] last_wstrb [NS];

    assign slv_arready = ~rd_busy;
    assign slv_awready = ~aw_got;
    assign slv_wready  = ~w_got;
    assign slv_rresp   = '0;
    assign slv_bresp   = '0;

    initial begin
        for (int i = 0; i < NS; i++) wr_cnt[i] = 0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_busy    <= '0;
            aw_got     <= '0;
            w_got      <= '0;
            slv_rvalid <= '0;
            slv_bvalid <= '0;
            slv_rdata  <= '0;
            for (int i = 0; i < NS; i++) rd_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (slv_arvalid[i] && !rd_busy[i]) begin
                    rd_busy[i] <= 1'b1;
                    rd_cnt[i]  <= (rd_delay[i] < 1) ? 1 : rd_delay[i];
                end else if (rd_busy[i] && !slv_rvalid[i]) begin
                    if (rd_cnt[i] <= 1) begin
                        slv_rvalid[i] <= 1'b1;
                        slv_rdata[i*DW +: DW] <= rd_val[i];
                    end else begin
                        rd_cnt[i] <= rd_cnt[i] - 1;
                    end
                end
                if (slv_rvalid[i] && slv_rready[i]) begin
                    slv_rvalid[i] <= 1'b0;
                    rd_busy[i]    <= 1'b0;
                end
                if (slv_awvalid[i] && !aw_got[i]) begin
                    aw_got[i]    <= 1'b1;
                    lat_waddr[i] <= slv_awaddr[i*AW +: AW];
                end
                if (slv_wvalid[i] && !w_got[i]) begin
                    w_got[i]     <= 1'b1;
                    lat_wdata[i] <= slv_wdata[i*DW +: DW];
                    lat_wstrb[i] <= slv_wstrb[i*SW +: SW];
                end
                if (aw_got[i] && w_got[i] && !slv_bvalid[i]) begin
                    slv_bvalid[i] <= 1'b1;
                    wr_cnt[i]     <= wr_cnt[i] + 1;
                    last_waddr[i] <= lat_waddr[i];
                    last_wdata[i] <= lat_wdata[i];
                    last_wstrb[i] <= lat_wstrb[i];
                end
                if (slv_bvalid[i] && slv_bready[i]) begin
                    slv_bvalid[i] <= 1'b0;
                    aw_got[i]     <= 1'b0;
                    w_got[i]      <= 1'b0;
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            fails  = 0;
    logic [33:0]   rd_q [$];
    logic [1:0]    wr_q [$];
    int            arv_seen [NS];
    int            awv_seen [NS];
    int            wv_seen  [NS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp,
                 slv_arvalid, slv_araddr, slv_rready, slv_awvalid, slv_awaddr,
                 slv_wvalid, slv_wdata, slv_wstrb, slv_bready};
    endfunction

    task automatic monitor();
        logic [33:0] er;
        logic [1:0]  eb;
        for (int i = 0; i < NS; i++) begin
            arv_seen[i] = 0; awv_seen[i] = 0; wv_seen[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NS; i++) begin
                arv_seen[i] += int'(slv_arvalid[i]);
                awv_seen[i] += int'(slv_awvalid[i]);
                wv_seen[i]  += int'(slv_wvalid[i]);
            end
            if (slv_arvalid != '0) check("ar_onehot", 64'($onehot(slv_arvalid)), 1);
            if (slv_awvalid != '0) check("aw_onehot", 64'($onehot(slv_awvalid)), 1);
            if (!rst && rvalid && rready) begin
                if (rd_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL rd_unexpected: got R beat rdata=0x%0h rresp=%0d, expected none", rdata, rresp);
                end else begin
                    er = rd_q.pop_front();
                    check("rd_resp", {rresp, rdata}, er);
                end
            end
            if (!rst && bvalid && bready) begin
                if (wr_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL wr_unexpected: got B beat bresp=%0d, expected none", bresp);
                end else begin
                    eb = wr_q.pop_front();
                    check("wr_bresp", bresp, eb);
                end
            end
        end
    endtask

    // ---------------- master driver ----------------
    task automatic do_read(input logic [AW-1:0] a, input logic [NS-1:0] exp_arv, input logic exp_err);
        bit ok;
        araddr = a; arvalid = 1'b1; ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0; araddr = '0;
        if (!ok) check("rd_ar_timeout", 0, 1);
        @(negedge clk);
        if (exp_err) check("rd_err_latency", rvalid, 1);
        else         check("rd_ar_latency", slv_arvalid, exp_arv);
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            if (rvalid && rready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) check("rd_r_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input int lead);
        bit ok;
        wdata = d; wstrb = s;
        fork
            begin
                bit okw;
                okw = 0; wvalid = 1'b1;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (wready) begin okw = 1; break; end
                end
                @(posedge clk); #1;
                wvalid = 1'b0;
                if (!okw) check("wr_w_timeout", 0, 1);
            end
            begin
                bit oka;
                oka = 0;
                repeat (lead) @(posedge clk);
                if (lead > 0) #1;
                awaddr = a; awvalid = 1'b1;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (awready) begin oka = 1; break; end
                end
                @(posedge clk); #1;
                awvalid = 1'b0; awaddr = '0;
                if (!oka) check("wr_aw_timeout", 0, 1);
            end
        join
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bvalid && bready) begin ok = 1; break; end
        end
        if (!ok) check("wr_b_timeout", 0, 1);
        @(posedge clk); #1;
        wdata = '0; wstrb = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  base [NS];
        int  c0, w0, n;
        bit  ok;
        arvalid = 0; araddr = '0; rready = 1;
        awvalid = 0; awaddr = '0; wvalid = 0; wdata = '0; wstrb = '0; bready = 1;
        for (int i = 0; i < NS; i++) begin rd_delay[i] = 1; rd_val[i] = '0; end
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        #1 check("reset_outputs_zero", any_out(), 0);
        rst = 1'b0; #1;
        check("ready_after_reset", {arready, awready}, 2'b11);

        // Slave 0 read with a 3-cycle slave delay.
        rd_delay[0] = 3; rd_val[0] = 32'h55;
        for (int i = 0; i < NS; i++) base[i] = arv_seen[i];
        rd_q.push_back({2'b00, 32'h0000_0055});
        do_read(32'ha000_03f8, 3'b001, 1'b0);
        check("rd0_arvalid_s0", 64'(arv_seen[0] > base[0]), 1);
        check("rd0_arvalid_others", (arv_seen[1] - base[1]) + (arv_seen[2] - base[2]), 0);

        // Unmapped read answered locally.
        for (int i = 0; i < NS; i++) base[i] = arv_seen[i];
        rd_q.push_back({2'b11, 32'h0});
        do_read(32'h1000_0000, 3'b000, 1'b1);
        check("rderr_no_arvalid", (arv_seen[0] - base[0]) + (arv_seen[1] - base[1]) + (arv_seen[2] - base[2]), 0);

        // Reads to slaves 1 and 2.
        rd_delay[1] = 1; rd_val[1] = 32'h1111_2222;
        rd_q.push_back({2'b00, 32'h1111_2222});
        do_read(32'ha000_004c, 3'b010, 1'b0);
        rd_delay[2] = 2; rd_val[2] = 32'hcafe_f00d;
        rd_q.push_back({2'b00, 32'hcafe_f00d});
        do_read(32'h8765_4320, 3'b100, 1'b0);

        // Writes to slave 2: W two cycles before AW, then both together.
        w0 = wr_cnt[2];
        wr_q.push_back(2'b00);
        do_write(32'h8000_0010, 32'hdead_beef, 4'hf, 2);
        check("wr_lead_cnt", wr_cnt[2] - w0, 1);
        check("wr_lead_addr", last_waddr[2], 32'h8000_0010);
        check("wr_lead_data", last_wdata[2], 32'hdead_beef);
        check("wr_lead_strb", last_wstrb[2], 4'hf);
        wr_q.push_back(2'b00);
        do_write(32'h8000_0010, 32'hdead_beef, 4'hf, 0);
        check("wr_same_cnt", wr_cnt[2] - w0, 2);
        check("wr_same_data", last_wdata[2], 32'hdead_beef);

        // Concurrent read and write on slave 1.
        rd_val[1] = 32'h0bad_cafe;
        rd_q.push_back({2'b00, 32'h0bad_cafe});
        wr_q.push_back(2'b00);
        w0 = wr_cnt[1]; c0 = cyc;
        fork
            do_read(32'ha000_0048, 3'b010, 1'b0);
            do_write(32'ha000_004c, 32'h0123_4567, 4'h3, 0);
        join
        check("concurrent_no_stall", 64'((cyc - c0) <= 8), 1);
        check("conc_wr_cnt", wr_cnt[1] - w0, 1);
        check("conc_wr_addr", last_waddr[1], 32'ha000_004c);
        check("conc_wr_data", last_wdata[1], 32'h0123_4567);
        check("conc_wr_strb", last_wstrb[1], 4'h3);

        // Unmapped write: beat absorbed, DECERR returned.
        for (int i = 0; i < NS; i++) base[i] = wv_seen[i];
        c0 = awv_seen[0] + awv_seen[1] + awv_seen[2];
        wr_q.push_back(2'b11);
        do_write(32'h0000_0000, 32'hffff_ffff, 4'hf, 0);
        check("wrerr_no_wvalid", (wv_seen[0] - base[0]) + (wv_seen[1] - base[1]) + (wv_seen[2] - base[2]), 0);
        check("wrerr_no_awvalid", (awv_seen[0] + awv_seen[1] + awv_seen[2]) - c0, 0);

        // Reset while waiting in R_DATA.
        rd_delay[0] = 2; rd_val[0] = 32'h7777_0000; rready = 1'b0;
        araddr = 32'ha000_03f8; arvalid = 1'b1; ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (arready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0; araddr = '0;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rvalid) begin ok = 1; break; end
        end
        check("rdata_state_reached", ok, 1);
        #1 rst = 1'b1;
        #1 check("rst_mid_outputs_zero", any_out(), 0);
        rready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("ready_after_reset2", arready, 1);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (rvalid) n++;
        end
        check("no_resp_after_reset", n, 0);
        @(posedge clk); #1;

        // Normal read after reset release.
        rd_delay[0] = 1; rd_val[0] = 32'h0000_00aa;
        rd_q.push_back({2'b00, 32'h0000_00aa});
        do_read(32'ha000_03f8, 3'b001, 1'b0);

        for (int k = 0; k < 100; k++) begin
            if (rd_q.size() == 0 && wr_q.size() == 0) break;
            @(posedge clk);
        end
        check("scoreboard_drained", rd_q.size() + wr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/axi4lite_xbar_nslv.md
AXI4LITE_XBAR_NSLV -- requirements
Module: axi4lite_xbar_nslv

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width; wstrb width is DATA_WIDTH/8.
REQ-003 SHALL have parameter NUM_SLAVES, default 3, meaning slave port count (1..8).
REQ-004 SHALL have parameter SLV_BASE, default {32'h8000_0000, 32'ha000_0048, 32'ha000_03f8}, meaning per-slave base addresses, flattened, slave 0 in LSBs.
REQ-005 SHALL have parameter SLV_MASK, default {32'hf800_0000, 32'hffff_fff8, 32'hffff_fffc}, meaning per-slave compare masks, flattened.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 arvalid in 1; araddr in ADDR_WIDTH; arready out 1: master read address.
REQ-009 rvalid out 1; rdata out DATA_WIDTH; rresp out 2; rready in 1: master read data.
REQ-010 awvalid in 1; awaddr in ADDR_WIDTH; awready out 1: master write address.
REQ-011 wvalid in 1; wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wready out 1: master write data.
REQ-012 bvalid out 1; bresp out 2; bready in 1: master write response.
REQ-013 Each master signal x SHALL have a slave-side mirror slv_x, direction reversed, width NUM_SLAVES times the master width, slave i at bits [i*W +: W].

Function
REQ-014 Slave i SHALL hit when (addr & SLV_MASK[i]) == SLV_BASE[i]; if several hit, lowest index wins; if none hit, the access is a decode error.
REQ-015 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA, R_ERR.
REQ-016 R_IDLE: arready=1; on arvalid, register araddr and the decoded target; go to R_ADDR, or to R_ERR on decode error.
REQ-017 R_ADDR: slv_arvalid[t]=1 with the registered address, held until slv_arready[t]; then go to R_DATA.
REQ-018 R_DATA: rvalid, rdata and rresp pass through combinationally from slave t; slv_rready[t]=rready; on rvalid&&rready, go to R_IDLE.
REQ-019 R_ERR: rvalid=1, rdata=0, rresp=2'b11 (DECERR), held until rready; no slave is touched; then go to R_IDLE.
REQ-020 Write FSM SHALL have states W_IDLE, W_FWD, W_RESP, W_ERR_W, W_ERR_B.
REQ-021 W_IDLE: awready=1, wready=0; on awvalid, register awaddr and target; go to W_FWD, or to W_ERR_W on decode error.
REQ-022 W_FWD: slv_awvalid[t] is held until handshake and then sets flag aw_done; wvalid/wdata/wstrb pass to slave t and wready=slv_wready[t] until handshake, which sets flag w_done; the two may complete in either order or in the same cycle; when both flags are set, go to W_RESP.
REQ-023 W_RESP: bvalid and bresp pass through from slave t; slv_bready[t]=bready; on handshake, clear the flags and go to W_IDLE.
REQ-024 W_ERR_W: wready=1; one beat is accepted and discarded; then W_ERR_B: bvalid=1, bresp=2'b11 until bready; then go to W_IDLE.
REQ-025 At most one outstanding transaction per direction; the read and write FSMs are independent and may target the same slave concurrently.
REQ-026 All slave-side valid/ready outputs of non-target slaves SHALL be 0; master valid outputs SHALL be 0 in idle states.
REQ-027 Minimum latency: AR accept to slv_arvalid is 1 cycle; a decode-error read gives rvalid 1 cycle after the AR handshake.

Reset
REQ-028 While rst is high, all outputs SHALL be 0, both FSMs SHALL be idle, and the flags and registered addresses SHALL be cleared.
REQ-029 arready and awready SHALL first assert in the first cycle after rst deasserts.
REQ-030 Reset asserted mid-transaction SHALL abandon it immediately; no response is generated after reset.

Structure
REQ-031 Package axi4lite_xbar_pkg SHALL hold RESP_OKAY=2'b00, RESP_DECERR=2'b11, and the read/write state encodings.
REQ-032 Sub-module axi4lite_addr_decode (combinational: addr -> one-hot hit and err) SHALL be instantiated once for AR and once for AW.

Verification
REQ-033 Read 0xa000_03f8; slave 0 returns 0x55 after a 3-cycle delay -> rdata=0x55, rresp=00, only slv_arvalid[0] ever high.
REQ-034 Read 0x1000_0000 -> no slv_arvalid pulse; rvalid 1 cycle after the AR handshake with rdata=0, rresp=11.
REQ-035 Write 0x8000_0010, data 0xdeadbeef, wstrb 4'hf, with W presented 2 cycles before AW, and again with both in the same cycle -> slave 2 receives both; bresp=00.
REQ-036 Concurrent read 0xa000_0048 and write 0xa000_004c -> both complete on slave 1 with no cross-channel stall.
REQ-037 Write 0x0 -> the W beat is absorbed, then bresp=11; slave wvalid stays 0 throughout.
REQ-038 rst asserted while in R_DATA -> all outputs 0 in the same cycle; a new read after release completes normally.
